fifo_wr_packer: RTL and testbench



---
 rtl/fifo_wr_pkg.sv | 19 +
 rtl/fifo_wr_packer_if.sv | 38 +++
 rtl/fifo_wr_hold_reg.sv | 44 ++++
 rtl/fifo_wr_packer.sv | 144 ++++++++++++++
 tb/tb_fifo_wr_packer.sv | 324 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_wr_pkg.sv
// Shared types and sizing helpers for the async-FIFO write-side packer.
package fifo_wr_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ACC       = 2'd1,
    LAST_PEND = 2'd2
  } state_t;

  function automatic int out_width(input int in_width, input int ratio);
    return in_width * ratio;
  endfunction

  // The lane index keeps at least one bit so RATIO=2 still has a usable counter.
  function automatic int lane_width(input int ratio);
    return (ratio > 2) ? $clog2(ratio) : 1;
  endfunction

endpackage

// File: rtl/fifo_wr_packer_if.sv
// Beat stream in, FIFO write port out, plus per-packet status and debug state.
interface fifo_wr_packer_if
  import fifo_wr_pkg::*;
#(
  parameter int IN_WIDTH  = 8,
  parameter int RATIO     = 2,
  parameter int CNT_WIDTH = 16
) ();

  localparam int OUT_WIDTH = out_width(IN_WIDTH, RATIO);

  // Handshake: a beat transfers on a wr_clk edge where in_valid && in_ready;
  // in_valid/in_data/in_last hold until that edge. A FIFO word is written on
  // every edge where fifo_wr_en is high, which only happens while fifo_full is low.
  logic                 clr;
  logic                 in_valid;
  logic [IN_WIDTH-1:0]  in_data;
  logic                 in_last;
  logic                 in_ready;
  logic                 fifo_full;
  logic                 fifo_wr_en;
  logic [OUT_WIDTH-1:0] fifo_din;
  logic                 pkt_done;
  logic [CNT_WIDTH-1:0] pkt_words;
  logic                 pkt_padded;
  state_t               dbg_state;

  modport master (
    input  clr, in_valid, in_data, in_last, fifo_full,
    output in_ready, fifo_wr_en, fifo_din, pkt_done, pkt_words, pkt_padded, dbg_state
  );

  modport slave (
    output clr, in_valid, in_data, in_last, fifo_full,
    input  in_ready, fifo_wr_en, fifo_din, pkt_done, pkt_words, pkt_padded, dbg_state
  );

endinterface

// File: rtl/fifo_wr_hold_reg.sv
// One-word staging register in front of the FIFO write port.
module fifo_wr_hold_reg #(
  parameter int OUT_WIDTH = 16
) (
  input  logic                 wr_clk,
  input  logic                 rst_n,
  input  logic                 i_clr,
  input  logic                 i_load,
  input  logic [OUT_WIDTH-1:0] i_load_data,
  input  logic                 i_fifo_full,
  output logic                 o_hold_valid,
  output logic                 o_drain,
  output logic                 o_fifo_wr_en,
  output logic [OUT_WIDTH-1:0] o_fifo_din
);

  logic                 r_hold_valid;
  logic [OUT_WIDTH-1:0] r_hold_data;
  logic                 w_drain;

  assign w_drain = r_hold_valid && !i_fifo_full;

  // A load in the same cycle as a drain refills the register without a gap.
  always_ff @(posedge wr_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold_valid <= 1'b0;
      r_hold_data  <= '0;
    end else if (i_clr) begin
      r_hold_valid <= 1'b0;
      r_hold_data  <= '0;
    end else if (i_load) begin
      r_hold_valid <= 1'b1;
      r_hold_data  <= i_load_data;
    end else if (w_drain) begin
      r_hold_valid <= 1'b0;
    end
  end

  assign o_hold_valid = r_hold_valid;
  assign o_drain      = w_drain;
  assign o_fifo_wr_en = w_drain;
  assign o_fifo_din   = r_hold_data;

endmodule

// File: rtl/fifo_wr_packer.sv
// Packs IN_WIDTH beats into RATIO-lane FIFO words, grouped into packets by in_last.
module fifo_wr_packer
  import fifo_wr_pkg::*;
#(
  parameter int IN_WIDTH  = 8,
  parameter int RATIO     = 2,
  parameter int CNT_WIDTH = 16
) (
  input  logic             wr_clk,
  input  logic             rst_n,
  fifo_wr_packer_if.master bus
);

  localparam int OUT_WIDTH = out_width(IN_WIDTH, RATIO);
  localparam int LANE_W    = lane_width(RATIO);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(RATIO - 1);

  state_t                         r_state;
  state_t                         w_next_state;
  logic [LANE_W-1:0]              r_lane;
  logic [RATIO-1:0][IN_WIDTH-1:0] r_acc;
  logic [RATIO-1:0][IN_WIDTH-1:0] w_word;
  logic [CNT_WIDTH-1:0]           r_word_cnt;
  logic                           r_pad_pend;
  logic                           r_pkt_done;
  logic [CNT_WIDTH-1:0]           r_pkt_words;
  logic                           r_pkt_padded;

  logic w_hold_valid;
  logic w_drain;
  logic w_in_ready;
  logic w_accept;
  logic w_completes;
  logic w_load;
  logic w_pkt_end;

  // Ready does not look at in_valid or in_last, so the source never sees it flicker.
  assign w_in_ready  = (r_state != LAST_PEND) && (!w_hold_valid || w_drain);
  assign w_accept    = bus.in_valid && w_in_ready && !bus.clr;
  assign w_completes = (r_lane == LAST_LANE) || bus.in_last;
  assign w_load      = w_accept && w_completes;
  assign w_pkt_end   = (r_state == LAST_PEND) && w_drain;

  // Completed word: stored lanes below the current one, the incoming beat, zeros above.
  always_comb begin
    w_word = '0;
    for (int i = 0; i < RATIO; i++) begin
      if (LANE_W'(i) < r_lane) begin
        w_word[i] = r_acc[i];
      end else if (LANE_W'(i) == r_lane) begin
        w_word[i] = bus.in_data;
      end
    end
  end

  always_ff @(posedge wr_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lane     <= '0;
      r_acc      <= '0;
      r_word_cnt <= '0;
      r_pad_pend <= 1'b0;
    end else if (bus.clr) begin
      r_lane     <= '0;
      r_acc      <= '0;
      r_word_cnt <= '0;
      r_pad_pend <= 1'b0;
    end else begin
      if (w_accept) begin
        if (w_completes) begin
          r_lane <= '0;
          if (r_word_cnt != '1) begin
            r_word_cnt <= r_word_cnt + CNT_WIDTH'(1);
          end
        end else begin
          r_acc[r_lane] <= bus.in_data;
          r_lane        <= r_lane + LANE_W'(1);
        end
        if (bus.in_last) begin
          r_pad_pend <= (r_lane != LAST_LANE);
        end
      end
      if (w_pkt_end) begin
        r_word_cnt <= '0;
      end
    end
  end

  always_ff @(posedge wr_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else if (bus.clr) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      IDLE:      if (w_accept) w_next_state = bus.in_last ? LAST_PEND : ACC;
      ACC:       if (w_accept && bus.in_last) w_next_state = LAST_PEND;
      LAST_PEND: if (w_drain) w_next_state = IDLE;
      default:   w_next_state = IDLE;
    endcase
  end

  // Status is captured on the edge that writes the packet's final word.
  always_ff @(posedge wr_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pkt_done   <= 1'b0;
      r_pkt_words  <= '0;
      r_pkt_padded <= 1'b0;
    end else begin
      r_pkt_done <= w_pkt_end && !bus.clr;
      if (w_pkt_end && !bus.clr) begin
        r_pkt_words  <= r_word_cnt;
        r_pkt_padded <= r_pad_pend;
      end
    end
  end

  fifo_wr_hold_reg #(
    .OUT_WIDTH (OUT_WIDTH)
  ) u_hold (
    .wr_clk       (wr_clk),
    .rst_n        (rst_n),
    .i_clr        (bus.clr),
    .i_load       (w_load),
    .i_load_data  (w_word),
    .i_fifo_full  (bus.fifo_full),
    .o_hold_valid (w_hold_valid),
    .o_drain      (w_drain),
    .o_fifo_wr_en (bus.fifo_wr_en),
    .o_fifo_din   (bus.fifo_din)
  );

  assign bus.in_ready   = w_in_ready;
  assign bus.pkt_done   = r_pkt_done;
  assign bus.pkt_words  = r_pkt_words;
  assign bus.pkt_padded = r_pkt_padded;
  assign bus.dbg_state  = r_state;

endmodule

// File: tb/tb_fifo_wr_packer.sv
// Bench for fifo_wr_packer: directed packet table, clr/full/reset sequences, random packets.
module tb_fifo_wr_packer;
  import fifo_wr_pkg::*;

  localparam int IN_W  = 8;
  localparam int R     = 2;
  localparam int CNT_W = 4;
  localparam int OUT_W = IN_W * R;
  localparam int SAT   = (1 << CNT_W) - 1;

  logic wr_clk = 1'b0;
  logic rst_n  = 1'b0;

  fifo_wr_packer_if #(.IN_WIDTH(IN_W), .RATIO(R), .CNT_WIDTH(CNT_W)) bus ();

  fifo_wr_packer #(.IN_WIDTH(IN_W), .RATIO(R), .CNT_WIDTH(CNT_W)) dut (
    .wr_clk (wr_clk),
    .rst_n  (rst_n),
    .bus    (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 wr_clk = ~wr_clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [OUT_W:0]   exp_q[$];   // {is_last_word_of_packet, word}
  logic [CNT_W:0]   st_q[$];    // {padded, pkt_words}
  logic [IN_W-1:0]  pkt_q[$];
  logic             expect_done = 1'b0;
  logic             rand_full_en = 1'b0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, req);
    end
  endfunction

  // Reference model: packet beats -> little-endian lane words, zero-padded tail.
  task automatic model_packet();
    int n;
    int nw;
    int pw;
    logic [OUT_W-1:0] w;
    n  = pkt_q.size();
    nw = (n + R - 1) / R;
    for (int k = 0; k < nw; k++) begin
      w = '0;
      for (int j = 0; j < R; j++) begin
        if (k * R + j < n) w = w | (OUT_W'(pkt_q[k * R + j]) << (IN_W * j));
      end
      exp_q.push_back({(k == nw - 1), w});
    end
    pw = (nw > SAT) ? SAT : nw;
    st_q.push_back({((n % R) != 0), CNT_W'(pw)});
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [OUT_W:0] e;
    logic [CNT_W:0] s;
    forever begin
      @(negedge wr_clk);
      if (!rst_n) begin
        expect_done = 1'b0;
      end else begin
        if (bus.pkt_done || expect_done) begin
          check("pkt_done_timing", 32'(bus.pkt_done), 32'(expect_done));
          if (bus.pkt_done) begin
            if (st_q.size() == 0) begin
              check("pkt_done_unexpected", 32'(1), 32'(0));
            end else begin
              s = st_q.pop_front();
              check("pkt_words", 32'(bus.pkt_words), 32'(s[CNT_W-1:0]));
              check("pkt_padded", 32'(bus.pkt_padded), 32'(s[CNT_W]));
            end
          end
        end
        expect_done = 1'b0;
        if (bus.fifo_wr_en && !bus.clr) begin
          check("write_while_full", 32'(bus.fifo_full), 32'(0));
          if (exp_q.size() == 0) begin
            check("unexpected_write", 32'(bus.fifo_din), 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            check("fifo_din", 32'(bus.fifo_din), 32'(e[OUT_W-1:0]));
            expect_done = e[OUT_W];
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge wr_clk);
      #1;
      if (rand_full_en) bus.fifo_full = ($urandom_range(0, 3) == 0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_beat(input logic [IN_W-1:0] d, input logic last);
    int waited;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    waited = 0;
    forever begin
      @(negedge wr_clk);
      if (bus.in_ready) break;
      waited++;
      if (waited > 200) begin
        check("in_ready_timeout", 32'(waited), 32'(0));
        break;
      end
    end
    @(posedge wr_clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic send_pkt_q(input bit gaps);
    for (int i = 0; i < pkt_q.size(); i++) begin
      if (gaps && $urandom_range(0, 4) == 0) begin
        repeat ($urandom_range(1, 3)) begin
          @(posedge wr_clk);
          #1;
        end
      end
      send_beat(pkt_q[i], (i == pkt_q.size() - 1));
    end
  endtask

  task automatic wait_drain(input string name);
    int cyc;
    cyc = 0;
    while ((exp_q.size() != 0 || st_q.size() != 0) && cyc < 400) begin
      @(posedge wr_clk);
      #1;
      cyc++;
    end
    check({name, "_drain"}, 32'(exp_q.size() + st_q.size()), 32'(0));
    repeat (2) begin
      @(posedge wr_clk);
      #1;
    end
  endtask

  // ---------------- directed table ----------------
  typedef struct packed {
    logic [3:0]                n_beats;
    logic [7:0][IN_W-1:0]      beats;
    logic [2:0]                n_words;
    logic [3:0][OUT_W-1:0]     words;
    logic [CNT_W-1:0]          pkt_words;
    logic                      padded;
  } vec_t;

  vec_t vecs[5];

  task automatic run_table();
    vecs[0].n_beats = 4'd4; vecs[0].beats = 64'h44332211;     vecs[0].n_words = 3'd2;
    vecs[0].words = 64'h4433_2211;           vecs[0].pkt_words = 4'd2; vecs[0].padded = 1'b0;
    vecs[1].n_beats = 4'd3; vecs[1].beats = 64'hCCBBAA;       vecs[1].n_words = 3'd2;
    vecs[1].words = 64'h00CC_BBAA;           vecs[1].pkt_words = 4'd2; vecs[1].padded = 1'b1;
    vecs[2].n_beats = 4'd1; vecs[2].beats = 64'h5A;           vecs[2].n_words = 3'd1;
    vecs[2].words = 64'h005A;                vecs[2].pkt_words = 4'd1; vecs[2].padded = 1'b1;
    vecs[3].n_beats = 4'd2; vecs[3].beats = 64'h0201;         vecs[3].n_words = 3'd1;
    vecs[3].words = 64'h0201;                vecs[3].pkt_words = 4'd1; vecs[3].padded = 1'b0;
    vecs[4].n_beats = 4'd5; vecs[4].beats = 64'h05_04030201;  vecs[4].n_words = 3'd3;
    vecs[4].words = 64'h0005_0403_0201;      vecs[4].pkt_words = 4'd3; vecs[4].padded = 1'b1;
    for (int v = 0; v < 5; v++) begin
      for (int k = 0; k < int'(vecs[v].n_words); k++) begin
        exp_q.push_back({(k == int'(vecs[v].n_words) - 1), vecs[v].words[k]});
      end
      st_q.push_back({vecs[v].padded, vecs[v].pkt_words});
      for (int b = 0; b < int'(vecs[v].n_beats); b++) begin
        send_beat(vecs[v].beats[b], (b == int'(vecs[v].n_beats) - 1));
      end
    end
    wait_drain("table");
  endtask

  // ---------------- hand-written sequences ----------------
  task automatic run_clr();
    exp_q.push_back({1'b0, 16'h7271});
    send_beat(8'h71, 1'b0);
    send_beat(8'h72, 1'b0);
    send_beat(8'h77, 1'b0);
    bus.clr = 1'b1;
    @(posedge wr_clk);
    #1;
    bus.clr = 1'b0;
    @(negedge wr_clk);
    check("clr_state", 32'(bus.dbg_state), 32'(IDLE));
    check("clr_hold_empty", 32'(bus.fifo_wr_en), 32'(0));
    @(posedge wr_clk);
    #1;
    pkt_q = '{8'h10, 8'h20};
    model_packet();
    send_pkt_q(1'b0);
    wait_drain("clr");
  endtask

  task automatic run_full_hold();
    bus.fifo_full = 1'b1;
    pkt_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    model_packet();
    fork
      send_pkt_q(1'b0);
      begin
        repeat (10) begin
          @(posedge wr_clk);
          #1;
        end
        @(negedge wr_clk);
        check("full_din_stable", 32'(bus.fifo_din), 32'h2211);
        check("full_no_write", 32'(bus.fifo_wr_en), 32'(0));
        check("full_backpressure", 32'({bus.in_valid, bus.in_ready}), 32'(2));
        @(posedge wr_clk);
        #1;
        bus.fifo_full = 1'b0;
        @(negedge wr_clk);
        check("release_write", 32'({bus.fifo_wr_en, bus.fifo_din}), 32'h1_2211);
      end
    join
    wait_drain("full");
  endtask

  task automatic run_random(input int n_pkts, input int max_beats);
    int n;
    rand_full_en = 1'b1;
    for (int p = 0; p < n_pkts; p++) begin
      n = $urandom_range(1, max_beats);
      pkt_q.delete();
      for (int i = 0; i < n; i++) pkt_q.push_back(IN_W'($urandom));
      model_packet();
      send_pkt_q(1'b1);
    end
    rand_full_en = 1'b0;
    @(posedge wr_clk);
    #1;
    bus.fifo_full = 1'b0;
    wait_drain("random");
  endtask

  task automatic run_saturate();
    pkt_q.delete();
    for (int i = 0; i < 40; i++) pkt_q.push_back(IN_W'($urandom));
    model_packet();
    send_pkt_q(1'b0);
    wait_drain("saturate");
  endtask

  task automatic run_reset_mid_packet();
    pkt_q = '{8'hEE};
    model_packet();
    send_pkt_q(1'b0);
    wait_drain("pre_reset");
    bus.fifo_full = 1'b1;
    send_beat(8'h11, 1'b0);
    send_beat(8'h22, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    check("rst_in_ready", 32'(bus.in_ready), 32'(1));
    check("rst_wr_en", 32'(bus.fifo_wr_en), 32'(0));
    check("rst_din", 32'(bus.fifo_din), 32'(0));
    check("rst_pkt", 32'({bus.pkt_done, bus.pkt_padded, bus.pkt_words}), 32'(0));
    bus.fifo_full = 1'b0;
    #1;
    check("rst_hold_cleared", 32'(bus.fifo_wr_en), 32'(0));
    check("rst_state", 32'(bus.dbg_state), 32'(IDLE));
    repeat (2) @(negedge wr_clk);
    rst_n = 1'b1;
    @(posedge wr_clk);
    #1;
    pkt_q = '{8'hC1, 8'hC2, 8'hC3};
    model_packet();
    send_pkt_q(1'b0);
    wait_drain("post_reset");
  endtask

  // ---------------- main sequence and report ----------------
  initial begin
    bus.clr       = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.fifo_full = 1'b0;
    #12;
    check("reset_in_ready", 32'(bus.in_ready), 32'(1));
    check("reset_wr_en", 32'(bus.fifo_wr_en), 32'(0));
    check("reset_din", 32'(bus.fifo_din), 32'(0));
    check("reset_pkt", 32'({bus.pkt_done, bus.pkt_padded, bus.pkt_words}), 32'(0));
    check("reset_state", 32'(bus.dbg_state), 32'(IDLE));
    @(negedge wr_clk);
    rst_n = 1'b1;
    @(posedge wr_clk);
    #1;

    run_table();
    run_clr();
    run_random(40, 9);
    run_saturate();
    run_full_hold();
    run_reset_mid_packet();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
